// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file writeback scheduler: widths and
// the source ids used to index the arbiter request/grant vectors.
package regfile_wb_scheduler_pkg;

    localparam int XLEN    = 64;
    localparam int AW      = 5;
    localparam int NREG    = 1 << AW;

    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, and on a tie
// the source that did not win the last transfer is granted.
module regfile_wb_scheduler_rr_arb2
    import regfile_wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_grant;

    // Grants are withheld during reset so no source sees ready.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (req[SRC_ALU] && (!req[SRC_MEM] || last_grant == 1'b1)) begin
                gnt[SRC_ALU] = 1'b1;
            end else if (req[SRC_MEM]) begin
                gnt[SRC_MEM] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= gnt[SRC_MEM];
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: arbitrates ALU/load results onto the single register
// file write port, registers the write, and tracks a busy scoreboard.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            s0_valid,
    input  logic [AW-1:0]   s0_rd,
    input  logic [XLEN-1:0] s0_data,
    output logic            s0_ready,
    input  logic            s1_valid,
    input  logic [AW-1:0]   s1_rd,
    input  logic [XLEN-1:0] s1_data,
    output logic            s1_ready,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    output logic            hazard,
    output logic            RegWrite,
    output logic [AW-1:0]   RD,
    output logic [XLEN-1:0] WriteData,
    output logic [NREG-1:0] busy
);

    logic [1:0]      gnt;
    logic            xfer;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [NREG-1:0] busy_next;

    regfile_wb_scheduler_rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    ({s1_valid, s0_valid}),
        .update (xfer),
        .gnt    (gnt)
    );

    assign s0_ready = gnt[SRC_ALU];
    assign s1_ready = gnt[SRC_MEM];
    assign xfer     = (s0_valid & gnt[SRC_ALU]) | (s1_valid & gnt[SRC_MEM]);
    assign sel_rd   = gnt[SRC_MEM] ? s1_rd   : s0_rd;
    assign sel_data = gnt[SRC_MEM] ? s1_data : s0_data;

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
        end else if (xfer) begin
            RegWrite  <= (sel_rd != '0);
            RD        <= sel_rd;
            WriteData <= sel_data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // Set is applied after clear so a new producer of the same rd wins.
    always_comb begin
        busy_next = busy;
        if (RegWrite) begin
            busy_next[RD] = 1'b0;
        end
        if (issue_valid && issue_rd != '0) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign hazard = ((issue_rs1 != '0) & busy[issue_rs1]) |
                    ((issue_rs2 != '0) & busy[issue_rs2]);

endmodule
